// File: rtl/instr_register_ctrl.sv
// Write/read sequencer for the instruction register: round-robin arbitration of two producers
// onto one write port, FIFO-ordered reads and occupancy tracking.
module instr_register_ctrl #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH),
    parameter int OPW   = 32,
    parameter int OPCW  = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   flush_i,
    input  logic                   wr0_req_i,
    input  logic signed [OPW-1:0]  wr0_op_a_i,
    input  logic signed [OPW-1:0]  wr0_op_b_i,
    input  logic        [OPCW-1:0] wr0_opc_i,
    output logic                   wr0_gnt_o,
    input  logic                   wr1_req_i,
    input  logic signed [OPW-1:0]  wr1_op_a_i,
    input  logic signed [OPW-1:0]  wr1_op_b_i,
    input  logic        [OPCW-1:0] wr1_opc_i,
    output logic                   wr1_gnt_o,
    input  logic                   rd_req_i,
    output logic                   rd_gnt_o,
    output logic                   rd_valid_o,
    output logic                   load_en_o,
    output logic        [AW-1:0]   write_pointer_o,
    output logic signed [OPW-1:0]  operand_a_o,
    output logic signed [OPW-1:0]  operand_b_o,
    output logic        [OPCW-1:0] opcode_o,
    output logic        [AW-1:0]   read_pointer_o,
    output logic        [AW:0]     count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic                   busy_s, full_s, empty_s, arb_sel1_s;
    logic                   wr0_gnt_s, wr1_gnt_s, wr_hs_s, rd_gnt_s;

    logic        [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                   rr_last_q, rr_last_d;
    logic        [AW:0]     count_q, count_d;
    logic                   load_en_q, load_en_d, rd_valid_q, rd_valid_d;
    logic        [AW-1:0]   write_pointer_q, write_pointer_d;
    logic        [AW-1:0]   read_pointer_q, read_pointer_d;
    logic signed [OPW-1:0]  operand_a_q, operand_a_d, operand_b_q, operand_b_d;
    logic        [OPCW-1:0] opcode_q, opcode_d;

    // Handshake decode; rr_last_q=1 means producer 1 won the last grant, so producer 0 wins next tie
    always_comb begin
        busy_s     = reset_i | flush_i;
        full_s     = (count_q == DEPTH_C);
        empty_s    = (count_q == (AW+1)'(0));
        arb_sel1_s = wr1_req_i & (~wr0_req_i | ~rr_last_q);
        wr0_gnt_s  = wr0_req_i & ~arb_sel1_s & ~full_s & ~busy_s;
        wr1_gnt_s  = wr1_req_i &  arb_sel1_s & ~full_s & ~busy_s;
        wr_hs_s    = wr0_gnt_s | wr1_gnt_s;
        rd_gnt_s   = rd_req_i & ~empty_s & ~busy_s;
    end

    // Next-state for pointers, occupancy, arbiter state and the registered write/read outputs
    always_comb begin
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        rr_last_d       = rr_last_q;
        count_d         = count_q;
        load_en_d       = 1'b0;
        rd_valid_d      = 1'b0;
        write_pointer_d = write_pointer_q;
        read_pointer_d  = read_pointer_q;
        operand_a_d     = operand_a_q;
        operand_b_d     = operand_b_q;
        opcode_d        = opcode_q;

        if (flush_i) begin
            // Flush clears everything except the fairness state
            wr_ptr_d        = AW'(0);
            rd_ptr_d        = AW'(0);
            count_d         = (AW+1)'(0);
            write_pointer_d = AW'(0);
            read_pointer_d  = AW'(0);
            operand_a_d     = OPW'(0);
            operand_b_d     = OPW'(0);
            opcode_d        = OPCW'(0);
        end else begin
            if (wr0_gnt_s) begin
                load_en_d       = 1'b1;
                write_pointer_d = wr_ptr_q;
                wr_ptr_d        = wr_ptr_q + AW'(1);
                operand_a_d     = wr0_op_a_i;
                operand_b_d     = wr0_op_b_i;
                opcode_d        = wr0_opc_i;
                rr_last_d       = 1'b0;
            end else if (wr1_gnt_s) begin
                load_en_d       = 1'b1;
                write_pointer_d = wr_ptr_q;
                wr_ptr_d        = wr_ptr_q + AW'(1);
                operand_a_d     = wr1_op_a_i;
                operand_b_d     = wr1_op_b_i;
                opcode_d        = wr1_opc_i;
                rr_last_d       = 1'b1;
            end else begin
                load_en_d       = 1'b0;
            end

            if (rd_gnt_s) begin
                rd_valid_d     = 1'b1;
                read_pointer_d = rd_ptr_q;
                rd_ptr_d       = rd_ptr_q + AW'(1);
            end else begin
                rd_valid_d     = 1'b0;
            end

            case ({wr_hs_s, rd_gnt_s})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State register with synchronous reset; producer 0 wins the first contested grant
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q        <= AW'(0);
            rd_ptr_q        <= AW'(0);
            rr_last_q       <= 1'b1;
            count_q         <= (AW+1)'(0);
            load_en_q       <= 1'b0;
            rd_valid_q      <= 1'b0;
            write_pointer_q <= AW'(0);
            read_pointer_q  <= AW'(0);
            operand_a_q     <= OPW'(0);
            operand_b_q     <= OPW'(0);
            opcode_q        <= OPCW'(0);
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            rr_last_q       <= rr_last_d;
            count_q         <= count_d;
            load_en_q       <= load_en_d;
            rd_valid_q      <= rd_valid_d;
            write_pointer_q <= write_pointer_d;
            read_pointer_q  <= read_pointer_d;
            operand_a_q     <= operand_a_d;
            operand_b_q     <= operand_b_d;
            opcode_q        <= opcode_d;
        end
    end

    assign wr0_gnt_o       = wr0_gnt_s;
    assign wr1_gnt_o       = wr1_gnt_s;
    assign rd_gnt_o        = rd_gnt_s;
    assign rd_valid_o      = rd_valid_q;
    assign load_en_o       = load_en_q;
    assign write_pointer_o = write_pointer_q;
    assign operand_a_o     = operand_a_q;
    assign operand_b_o     = operand_b_q;
    assign opcode_o        = opcode_q;
    assign read_pointer_o  = read_pointer_q;
    assign count_o         = count_q;
    assign full_o          = full_s;
    assign empty_o         = empty_s;

endmodule

// File: tb/tb_instr_register_ctrl.sv
// Directed bench for instr_register_ctrl: a vector table plus hand-written sequences for
// full/wrap/flush, with a model of the instruction register checking read data in FIFO order.
module tb_instr_register_ctrl;

    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int OPW   = 32;
    localparam int OPCW  = 4;
    localparam logic [OPCW-1:0] OPC_ADD  = 4'h1;
    localparam logic [67:0]     ADD_WORD = {4'h1, 32'hFFFF_FFFB, 32'h0000_0007};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   reset = 1'b1, flush = 1'b0;
    logic                   wr0_req = 1'b0, wr1_req = 1'b0, rd_req = 1'b0;
    logic signed [OPW-1:0]  wr0_op_a = '0, wr0_op_b = '0, wr1_op_a = '0, wr1_op_b = '0;
    logic        [OPCW-1:0] wr0_opc = '0, wr1_opc = '0;
    logic                   wr0_gnt, wr1_gnt, rd_gnt, rd_valid, load_en, full, empty;
    logic        [AW-1:0]   write_pointer, read_pointer;
    logic signed [OPW-1:0]  operand_a, operand_b;
    logic        [OPCW-1:0] opcode;
    logic        [AW:0]     count;

    int errors = 0;
    int checks = 0;

    instr_register_ctrl #(.DEPTH(DEPTH), .AW(AW), .OPW(OPW), .OPCW(OPCW)) dut (
        .clk_i(clk), .reset_i(reset), .flush_i(flush),
        .wr0_req_i(wr0_req), .wr0_op_a_i(wr0_op_a), .wr0_op_b_i(wr0_op_b), .wr0_opc_i(wr0_opc),
        .wr0_gnt_o(wr0_gnt),
        .wr1_req_i(wr1_req), .wr1_op_a_i(wr1_op_a), .wr1_op_b_i(wr1_op_b), .wr1_opc_i(wr1_opc),
        .wr1_gnt_o(wr1_gnt),
        .rd_req_i(rd_req), .rd_gnt_o(rd_gnt), .rd_valid_o(rd_valid),
        .load_en_o(load_en), .write_pointer_o(write_pointer),
        .operand_a_o(operand_a), .operand_b_o(operand_b), .opcode_o(opcode),
        .read_pointer_o(read_pointer), .count_o(count), .full_o(full), .empty_o(empty)
    );

    // Model of the instruction register fed by the controller's write port
    logic [67:0] ireg [DEPTH];
    logic [67:0] instruction_word;
    always @(posedge clk) if (load_en) ireg[write_pointer] <= {opcode, operand_a, operand_b};
    assign instruction_word = ireg[read_pointer];

    logic [67:0] exp_q[$];
    logic [67:0] last_word = '0;

    typedef struct {
        logic rs, fl, w0, w1, rd;
        logic g0, g1, rg;
        logic ld;
        logic [AW-1:0] wp;
        logic rv;
        logic [AW-1:0] rp;
        logic [AW:0] cnt;
    } vec_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_data(input int k);
        wr0_op_a = 32'(k * 3 - 50);
        wr0_op_b = -32'(k * 7);
        wr0_opc  = 4'(k);
        wr1_op_a = 32'(1000 + k);
        wr1_op_b = 32'(-1000 - k * 5);
        wr1_opc  = ~4'(k);
    endtask

    // One clock: drive at posedge+1, check grants and read data at negedge, return at posedge+1
    task automatic cycle(input logic w0, w1, rd, rs, fl, input logic eg0, eg1, erg);
        wr0_req = w0; wr1_req = w1; rd_req = rd; reset = rs; flush = fl;
        @(negedge clk);
        chk("wr0_gnt", wr0_gnt, eg0);
        chk("wr1_gnt", wr1_gnt, eg1);
        chk("rd_gnt", rd_gnt, erg);
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_data: rd_valid with no entry outstanding");
            end else begin
                chk("rd_data", instruction_word, exp_q.pop_front());
            end
        end
        if (eg0) begin
            last_word = {wr0_opc, wr0_op_a, wr0_op_b};
            exp_q.push_back(last_word);
        end else if (eg1) begin
            last_word = {wr1_opc, wr1_op_a, wr1_op_b};
            exp_q.push_back(last_word);
        end
        @(posedge clk); #1;
        if (rs || fl) begin
            exp_q.delete();
            last_word = '0;
        end
    endtask

    task automatic chk_regs(input logic ld, input logic [AW-1:0] wp, input logic rv,
                            input logic [AW-1:0] rp, input logic [AW:0] cnt);
        chk("load_en", load_en, ld);
        chk("write_pointer", write_pointer, wp);
        chk("rd_valid", rd_valid, rv);
        chk("read_pointer", read_pointer, rp);
        chk("count", count, cnt);
        chk("full", full, cnt == 6'd32);
        chk("empty", empty, cnt == 6'd0);
        chk("write_data", {opcode, operand_a, operand_b}, last_word);
    endtask

    function automatic vec_t mk(input logic rs, fl, w0, w1, rd, g0, g1, rg, ld,
                                input int wp, input logic rv, input int rp, input int cnt);
        vec_t v;
        v.rs = rs; v.fl = fl; v.w0 = w0; v.w1 = w1; v.rd = rd;
        v.g0 = g0; v.g1 = g1; v.rg = rg; v.ld = ld;
        v.wp = AW'(wp); v.rv = rv; v.rp = AW'(rp); v.cnt = (AW+1)'(cnt);
        return v;
    endfunction

    localparam int NV = 18;
    vec_t tbl [NV];

    initial begin
        //            rs fl w0 w1 rd  g0 g1 rg  ld wp rv rp cnt
        tbl[0]  = mk(1, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 1, 1, 1,  0, 0, 0,  0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 1, 0, 0,  1, 0, 0,  1, 0, 0, 0, 1);
        tbl[3]  = mk(0, 0, 0, 0, 1,  0, 0, 1,  0, 0, 1, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 1,  0, 0, 0,  0, 0, 0, 0, 0);
        tbl[5]  = mk(1, 0, 1, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0);
        tbl[6]  = mk(0, 0, 1, 1, 0,  1, 0, 0,  1, 0, 0, 0, 1);
        tbl[7]  = mk(0, 0, 1, 1, 0,  0, 1, 0,  1, 1, 0, 0, 2);
        tbl[8]  = mk(0, 0, 1, 1, 0,  1, 0, 0,  1, 2, 0, 0, 3);
        tbl[9]  = mk(0, 0, 1, 1, 0,  0, 1, 0,  1, 3, 0, 0, 4);
        tbl[10] = mk(0, 0, 0, 0, 0,  0, 0, 0,  0, 3, 0, 0, 4);
        tbl[11] = mk(0, 0, 0, 0, 1,  0, 0, 1,  0, 3, 1, 0, 3);
        tbl[12] = mk(0, 0, 0, 0, 1,  0, 0, 1,  0, 3, 1, 1, 2);
        tbl[13] = mk(0, 0, 0, 0, 1,  0, 0, 1,  0, 3, 1, 2, 1);
        tbl[14] = mk(0, 0, 0, 0, 1,  0, 0, 1,  0, 3, 1, 3, 0);
        tbl[15] = mk(0, 0, 1, 0, 0,  1, 0, 0,  1, 4, 0, 3, 1);
        tbl[16] = mk(0, 0, 0, 0, 1,  0, 0, 1,  0, 4, 1, 4, 0);
        tbl[17] = mk(0, 0, 0, 0, 0,  0, 0, 0,  0, 4, 0, 4, 0);

        @(posedge clk); #1;
        for (int i = 0; i < NV; i++) begin
            set_data(i + 100);
            if (i == 15) begin
                wr0_op_a = -32'sd5;
                wr0_op_b = 32'sd7;
                wr0_opc  = OPC_ADD;
            end
            cycle(tbl[i].w0, tbl[i].w1, tbl[i].rd, tbl[i].rs, tbl[i].fl,
                  tbl[i].g0, tbl[i].g1, tbl[i].rg);
            chk_regs(tbl[i].ld, tbl[i].wp, tbl[i].rv, tbl[i].rp, tbl[i].cnt);
            if (i == 16) chk("add_word", instruction_word, ADD_WORD);
        end

        // Fill to full, refuse the 33rd write, free one slot, then the pointer wraps to 0
        cycle(0, 0, 0, 1, 0, 0, 0, 0);
        chk_regs(0, 0, 0, 0, 0);
        for (int k = 0; k < DEPTH; k++) begin
            set_data(k);
            cycle(1, 0, 0, 0, 0, 1, 0, 0);
        end
        chk_regs(1, 31, 0, 0, 32);
        set_data(32);
        cycle(1, 1, 0, 0, 0, 0, 0, 0);
        chk_regs(0, 31, 0, 0, 32);
        cycle(1, 0, 1, 0, 0, 0, 0, 1);
        chk_regs(0, 31, 1, 0, 31);
        cycle(1, 0, 0, 0, 0, 1, 0, 0);
        chk_regs(1, 0, 0, 0, 32);

        // Steady simultaneous write and read across pointer wrap
        cycle(0, 0, 0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            set_data(200 + k);
            cycle(1, 0, 0, 0, 0, 1, 0, 0);
        end
        chk_regs(1, 2, 0, 0, 3);
        for (int k = 0; k < 40; k++) begin
            set_data(300 + k);
            cycle(1, 0, 1, 0, 0, 1, 0, 1);
            chk("count_steady", count, 6'd3);
        end
        chk_regs(1, 10, 1, 7, 3);

        // Flush with a read in flight; fairness state survives (producer 0 won last)
        for (int k = 0; k < 2; k++) begin
            set_data(400 + k);
            cycle(1, 0, 0, 0, 0, 1, 0, 0);
        end
        chk_regs(1, 12, 0, 7, 5);
        cycle(0, 0, 1, 0, 0, 0, 0, 1);
        chk_regs(0, 12, 1, 8, 4);
        cycle(1, 1, 1, 0, 1, 0, 0, 0);
        chk_regs(0, 0, 0, 0, 0);
        set_data(500);
        cycle(1, 1, 0, 0, 0, 0, 1, 0);
        chk_regs(1, 0, 0, 0, 1);
        cycle(0, 0, 1, 0, 0, 0, 0, 1);
        chk_regs(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        chk_regs(0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
